ula_seq_ctrl: RTL and testbench
===============================

Name: ula_seq_ctrl

Overview:
Multi-cycle sequencer that runs a W-bit ALU operation, with W = 4*NIBBLES, through one shared 4-bit ula_74181 slice, one nibble per cycle, LSB first.
- Latches the operands and the function select, drives the slice, ripples the slice carry between nibbles through a register, and assembles the result and flags.
- The slice is instantiated outside this block, in the parent, and is connected through the alu_* ports.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation (W = 4*NIBBLES, legal range 2..8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  operation request; accepted only in IDLE
op_a  in  W  operand A
op_b  in  W  operand B
s  in  4  74181 function select
m  in  1  mode (0 arithmetic, 1 logic)
c_in  in  1  carry into nibble 0, passed raw to the slice
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when result/flags are valid
result  out  W  assembled F word, held until next accepted start
c_out  out  1  carry out of the last nibble
a_eq_b  out  1  AND of the slice a_eq_b over all nibbles
zero  out  1  result == 0
alu_a  out  4  slice A
alu_b  out  4  slice B
alu_s  out  4  slice S (latched s)
alu_m  out  1  slice M (latched m)
alu_c_in  out  1  slice carry in
alu_f  in  4  slice F
alu_c_out  in  1  slice carry out
alu_a_eq_b  in  1  slice A=B

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst asynchronous, active-high; it forces state = IDLE, idx = 0, all internal registers 0.
  - Outputs during reset: busy = 0, done = 0, result = 0, c_out = 0, a_eq_b = 0, zero = 0, alu_* = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at a clock edge latches op_a, op_b, s, m, c_in, clears idx, sets the eq accumulator to 1, then moves to RUN.
  - start = 0 stays in IDLE.
- RUN:
  - Combinational drives:
    - alu_a = a_reg[4*idx +: 4]
    - alu_b = b_reg[4*idx +: 4]
    - alu_s = s_reg
    - alu_m = m_reg
    - alu_c_in = c_in_reg when idx == 0, otherwise carry_reg
  - At each edge:
    - result[4*idx +: 4] <= alu_f
    - carry_reg <= alu_c_out
    - eq_acc <= eq_acc & alu_a_eq_b
    - idx <= idx + 1
  - At the edge where idx == NIBBLES-1: c_out <= alu_c_out, a_eq_b <= final eq_acc (including this nibble), zero computed from the final result, and the FSM moves to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle after NIBBLES+1 rising edges counted from the accepting edge; start can be reaccepted the cycle after done.
- Carry is passed without inversion; polarity is whatever the slice uses, so ripple chaining is polarity-agnostic. Carry is chained in logic mode too; the slice ignores it.
- start in RUN or DONE is ignored, with no queuing. Operand/s/m/c_in changes after acceptance have no effect.
- Output holding:
  - Holding: result, c_out, a_eq_b and zero hold their values from the last completed operation through IDLE.
  - Update timing: they are overwritten only as RUN progresses. result is updated nibble-by-nibble during RUN and is valid only when done = 1.
  - alu_* outputs hold their last values outside RUN.
- Reset mid-RUN aborts immediately: no done pulse, outputs cleared, next start behaves normally.
- busy = (state == RUN). Otherwise busy and done are never high together.

Test Plan:
- The bench connects a behavioural slice model:
  - M=1, S=0110: F = A^B.
  - M=0, S=1001: {c_out, F} = A + B + c_in, with active-high carry.
  - a_eq_b = (F == 4'hF).
- Logic XOR, NIBBLES=4: op_a=16'hA5F0, op_b=16'h5AF0, m=1, s=0110, start pulse → busy for 4 cycles, done at cycle 5, result=16'hFF00, zero=0, a_eq_b=0.
- Add with carry ripple: op_a=16'h00FF, op_b=16'h0001, m=0, s=1001, c_in=0 → alu_c_in sequence 0,1,1,0; result=16'h0100, c_out=0.
- Overflow: op_a=16'hFFFF, op_b=16'h0001, c_in=0 → result=16'h0000, zero=1, c_out=1; then c_in=1 with op_b=0 → result=16'h0000, c_out=1.
- Start during busy: second start with different operands at RUN cycle 2 → ignored; first result delivered, exactly one done pulse. Back-to-back start in the cycle after done → accepted.
- Reset mid-op: assert rst at RUN idx=2 → busy, done, result and all flags go to 0 immediately, without waiting for a clock edge; no done pulse. A subsequent 16'h1234+16'h1111 → result=16'h2345.
- Parameter NIBBLES=2: 8'hF0+8'h10 → result=8'h00, c_out=1, done after 3 edges.

Source files
------------

// File: rtl/ula_seq_ctrl_if.sv
// Request/response and slice-side signals of the nibble-serial ALU sequencer.
// The slave modport is the sequencer; the master modport is the parent that owns the slice.
interface ula_seq_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [3:0]   s;
   logic         m;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         c_out;
   logic         a_eq_b;
   logic         zero;
   logic [3:0]   alu_a;
   logic [3:0]   alu_b;
   logic [3:0]   alu_s;
   logic         alu_m;
   logic         alu_c_in;
   logic [3:0]   alu_f;
   logic         alu_c_out;
   logic         alu_a_eq_b;

   modport slave (
      input  start, op_a, op_b, s, m, c_in,
      input  alu_f, alu_c_out, alu_a_eq_b,
      output busy, done, result, c_out, a_eq_b, zero,
      output alu_a, alu_b, alu_s, alu_m, alu_c_in
   );

   modport master (
      output start, op_a, op_b, s, m, c_in,
      output alu_f, alu_c_out, alu_a_eq_b,
      input  busy, done, result, c_out, a_eq_b, zero,
      input  alu_a, alu_b, alu_s, alu_m, alu_c_in
   );
endinterface

// File: rtl/ula_seq_ctrl.sv
// Runs a 4*NIBBLES-bit operation through one external 4-bit 74181 slice, LSB nibble first,
// rippling the slice carry through a register and assembling result and flags.
module ula_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic           clk,
   input  logic           rst,
   ula_seq_ctrl_if.slave  bus
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [3:0]       s_q;
   logic             m_q;
   logic             c_in_q;
   logic             carry_q;
   logic             eq_q;
   logic [W-1:0]     result_q;
   logic             c_out_q;
   logic             a_eq_b_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;

   logic [W-1:0]     result_d;
   logic             eq_d;

   // Only the nibble currently on the slice is replaced; the rest keep their value.
   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign result_d[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? bus.alu_f : result_q[4*gi +: 4];
   end

   assign eq_d = eq_q & bus.alu_a_eq_b;

   // idx and operands are frozen outside RUN, so the slice drives hold their last value.
   assign bus.alu_a    = a_q[4*idx_q +: 4];
   assign bus.alu_b    = b_q[4*idx_q +: 4];
   assign bus.alu_s    = s_q;
   assign bus.alu_m    = m_q;
   assign bus.alu_c_in = (idx_q == '0) ? c_in_q : carry_q;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.c_out  = c_out_q;
   assign bus.a_eq_b = a_eq_b_q;
   assign bus.zero   = zero_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         m_q      <= 1'b0;
         c_in_q   <= 1'b0;
         carry_q  <= 1'b0;
         eq_q     <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         a_eq_b_q <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.op_a;
                  b_q     <= bus.op_b;
                  s_q     <= bus.s;
                  m_q     <= bus.m;
                  c_in_q  <= bus.c_in;
                  idx_q   <= '0;
                  eq_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               eq_q     <= eq_d;
               if (idx_q == LAST_IDX) begin
                  c_out_q  <= bus.alu_c_out;
                  a_eq_b_q <= eq_d;
                  zero_q   <= (result_d == '0);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  carry_q <= bus.alu_c_out;
                  idx_q   <= idx_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed bench for ula_seq_ctrl with a behavioural 74181 slice (XOR and ADD functions only).
// Two instances: NIBBLES=4 for the main scenarios, NIBBLES=2 for the parameter case.
module tb_ula_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   ula_seq_ctrl_if #(.NIBBLES(4)) if4 ();
   ula_seq_ctrl_if #(.NIBBLES(2)) if2 ();

   ula_seq_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
   ula_seq_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   // {a_eq_b, c_out, f}; active-high carry in arithmetic mode
   function automatic logic [5:0] slice_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] s, input logic m, input logic cin);
      logic [4:0] sum;
      logic [3:0] f;
      logic       co;
      f  = 4'h0;
      co = 1'b0;
      if (m && s == 4'b0110) begin
         f = a ^ b;
      end else if (!m && s == 4'b1001) begin
         sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
         f   = sum[3:0];
         co  = sum[4];
      end
      return {(f == 4'hF), co, f};
   endfunction

   assign {if4.alu_a_eq_b, if4.alu_c_out, if4.alu_f} =
      slice_model(if4.alu_a, if4.alu_b, if4.alu_s, if4.alu_m, if4.alu_c_in);
   assign {if2.alu_a_eq_b, if2.alu_c_out, if2.alu_f} =
      slice_model(if2.alu_a, if2.alu_b, if2.alu_s, if2.alu_m, if2.alu_c_in);

   task automatic launch4(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, input logic m, input logic cin);
      @(negedge clk);
      if4.op_a  = a;
      if4.op_b  = b;
      if4.s     = s;
      if4.m     = m;
      if4.c_in  = cin;
      if4.start = 1'b1;
      @(negedge clk);
      if4.start = 1'b0;
   endtask

   // Called on the negedge after the accepting edge; returns on the negedge where done is seen.
   task automatic wait_done4(output int cyc, output int busy_cnt,
                             output logic [3:0] cin_seq, output bit timeout);
      cyc = 0; busy_cnt = 0; cin_seq = 4'h0; timeout = 1'b0;
      while (if4.done !== 1'b1) begin
         if (if4.busy === 1'b1) begin
            if (busy_cnt < 4) cin_seq[busy_cnt] = if4.alu_c_in;
            busy_cnt++;
         end
         if (cyc >= 20) begin
            timeout = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({if4.busy, if4.done, if4.c_out, if4.a_eq_b, if4.zero} !== 5'b0 || if4.result !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_out4 got busy/done/c/eq/z=%b%b%b%b%b result=%h want all 0",
                  if4.busy, if4.done, if4.c_out, if4.a_eq_b, if4.zero, if4.result);
      end
      vectors++;
      if ({if4.alu_a, if4.alu_b, if4.alu_s, if4.alu_m, if4.alu_c_in} !== 14'h0) begin
         miscompares++;
         $display("FAIL reset_alu4 got a=%h b=%h s=%h m=%b cin=%b want all 0",
                  if4.alu_a, if4.alu_b, if4.alu_s, if4.alu_m, if4.alu_c_in);
      end
      vectors++;
      if ({if2.busy, if2.done, if2.result} !== 10'h0) begin
         miscompares++;
         $display("FAIL reset_out2 got busy=%b done=%b result=%h want 0", if2.busy, if2.done, if2.result);
      end
      rst = 1'b0;
      $display("reset: outputs checked, reset released");
   endtask

   task automatic test_logic_xor();
      int cyc, bcnt;
      logic [3:0] cseq;
      bit to;
      launch4(16'hA5F0, 16'h5AF0, 4'b0110, 1'b1, 1'b0);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || cyc != 4 || bcnt != 4) begin
         miscompares++;
         $display("FAIL xor_latency got cyc=%0d busy=%0d to=%0b want cyc=4 busy=4", cyc, bcnt, to);
      end
      vectors++;
      if (if4.result !== 16'hFF00 || if4.zero !== 1'b0 || if4.a_eq_b !== 1'b0) begin
         miscompares++;
         $display("FAIL xor_result got %h z=%b eq=%b want ff00 z=0 eq=0", if4.result, if4.zero, if4.a_eq_b);
      end
      vectors++;
      if (if4.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL xor_busy_done got busy=%b with done, want 0", if4.busy);
      end
      @(negedge clk);
      vectors++;
      if (if4.done !== 1'b0 || if4.alu_a !== 4'hA || if4.result !== 16'hFF00) begin
         miscompares++;
         $display("FAIL xor_hold got done=%b alu_a=%h result=%h want 0 a ff00", if4.done, if4.alu_a, if4.result);
      end
      $display("xor a5f0^5af0: result=%h cycles=%0d", if4.result, cyc);

      launch4(16'hFFFF, 16'h0000, 4'b0110, 1'b1, 1'b0);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || if4.result !== 16'hFFFF || if4.a_eq_b !== 1'b1 || if4.zero !== 1'b0) begin
         miscompares++;
         $display("FAIL xor_eq got %h eq=%b z=%b to=%0b want ffff eq=1 z=0", if4.result, if4.a_eq_b, if4.zero, to);
      end
      $display("xor ffff^0000: result=%h a_eq_b=%b", if4.result, if4.a_eq_b);
   endtask

   task automatic test_add_ripple();
      int cyc, bcnt;
      logic [3:0] cseq;
      bit to;
      launch4(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || cseq !== 4'b0110) begin
         miscompares++;
         $display("FAIL add_cin_seq got %b (nib3..0) to=%0b want 0110", cseq, to);
      end
      vectors++;
      if (if4.result !== 16'h0100 || if4.c_out !== 1'b0 || if4.zero !== 1'b0) begin
         miscompares++;
         $display("FAIL add_result got %h c=%b z=%b want 0100 c=0 z=0", if4.result, if4.c_out, if4.zero);
      end
      $display("add 00ff+0001: result=%h c_out=%b cin_seq=%b", if4.result, if4.c_out, cseq);
   endtask

   task automatic test_overflow();
      int cyc, bcnt;
      logic [3:0] cseq;
      bit to;
      launch4(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || if4.result !== 16'h0000 || if4.zero !== 1'b1 || if4.c_out !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_b1 got %h z=%b c=%b to=%0b want 0000 z=1 c=1", if4.result, if4.zero, if4.c_out, to);
      end
      $display("add ffff+0001: result=%h c_out=%b zero=%b", if4.result, if4.c_out, if4.zero);
      launch4(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || if4.result !== 16'h0000 || if4.zero !== 1'b1 || if4.c_out !== 1'b1 || cseq[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_cin got %h z=%b c=%b cin0=%b want 0000 z=1 c=1 cin0=1",
                  if4.result, if4.zero, if4.c_out, cseq[0]);
      end
      $display("add ffff+0000+cin: result=%h c_out=%b", if4.result, if4.c_out);
   endtask

   task automatic test_start_during_busy();
      int pulses;
      logic [15:0] res;
      pulses = 0;
      res    = 16'h0;
      launch4(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      if4.op_a  = 16'h0F0F;
      if4.op_b  = 16'h7777;
      if4.c_in  = 1'b1;
      if4.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) if4.start = 1'b0;
         if (if4.done === 1'b1) begin
            pulses++;
            res = if4.result;
         end
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL busy_start_pulses got %0d done pulses want 1", pulses);
      end
      vectors++;
      if (res !== 16'h2345) begin
         miscompares++;
         $display("FAIL busy_start_result got %h want 2345", res);
      end
      $display("start during RUN: pulses=%0d result=%h", pulses, res);
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt;
      logic [3:0] cseq;
      bit to;
      launch4(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b0);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || if4.result !== 16'h0007) begin
         miscompares++;
         $display("FAIL b2b_first got %h to=%0b want 0007", if4.result, to);
      end
      launch4(16'hF0F0, 16'h0F0F, 4'b0110, 1'b1, 1'b0);
      vectors++;
      if (if4.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_accept got busy=%b want 1", if4.busy);
      end
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || cyc != 4 || if4.result !== 16'hFFFF || if4.a_eq_b !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second got %h eq=%b cyc=%0d to=%0b want ffff eq=1 cyc=4",
                  if4.result, if4.a_eq_b, cyc, to);
      end
      $display("back-to-back: second result=%h cycles=%0d", if4.result, cyc);
   endtask

   task automatic test_reset_mid_op();
      int cyc, bcnt;
      logic [3:0] cseq;
      bit to;
      launch4(16'hAAAA, 16'h5555, 4'b0110, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({if4.busy, if4.done, if4.c_out, if4.a_eq_b, if4.zero} !== 5'b0 || if4.result !== 16'h0 ||
          {if4.alu_a, if4.alu_b, if4.alu_s, if4.alu_m, if4.alu_c_in} !== 14'h0) begin
         miscompares++;
         $display("FAIL rst_mid_async got busy/done/c/eq/z=%b%b%b%b%b result=%h alu_a=%h want all 0",
                  if4.busy, if4.done, if4.c_out, if4.a_eq_b, if4.zero, if4.result, if4.alu_a);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_idle[%0d] got done=%b busy=%b want 0 0", i, if4.done, if4.busy);
         end
      end
      launch4(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
      wait_done4(cyc, bcnt, cseq, to);
      vectors++;
      if (to || cyc != 4 || if4.result !== 16'h2345 || if4.c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_after got %h c=%b cyc=%0d to=%0b want 2345 c=0 cyc=4",
                  if4.result, if4.c_out, cyc, to);
      end
      $display("reset mid-op then 1234+1111: result=%h", if4.result);
   endtask

   task automatic test_nibbles2();
      int cyc;
      cyc = 0;
      @(negedge clk);
      if2.op_a  = 8'hF0;
      if2.op_b  = 8'h10;
      if2.s     = 4'b1001;
      if2.m     = 1'b0;
      if2.c_in  = 1'b0;
      if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      while (if2.done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc != 2) begin
         miscompares++;
         $display("FAIL n2_latency got %0d edges after accept want 2", cyc);
      end
      vectors++;
      if (if2.result !== 8'h00 || if2.c_out !== 1'b1 || if2.zero !== 1'b1) begin
         miscompares++;
         $display("FAIL n2_result got %h c=%b z=%b want 00 c=1 z=1", if2.result, if2.c_out, if2.zero);
      end
      $display("nibbles=2 f0+10: result=%h c_out=%b edges=%0d", if2.result, if2.c_out, cyc + 1);
   endtask

   initial begin
      if4.start = 1'b0; if4.op_a = '0; if4.op_b = '0; if4.s = '0; if4.m = 1'b0; if4.c_in = 1'b0;
      if2.start = 1'b0; if2.op_a = '0; if2.op_b = '0; if2.s = '0; if2.m = 1'b0; if2.c_in = 1'b0;
      test_reset();
      test_logic_xor();
      test_add_ripple();
      test_overflow();
      test_start_during_busy();
      test_back_to_back();
      test_reset_mid_op();
      test_nibbles2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
